// File: rtl/regfile_loader.sv
// Register-file loader: streams words into (LOAD) or out of (DUMP) an attached register file.
// Optional running XOR checksum enabled by defining REGFILE_LOADER_CHECKSUM_EN.
module regfile_loader #(
    parameter int n          = 8,
    parameter int addr_width = 5,
    parameter int regcount   = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Mode,
    input  logic [addr_width-1:0] Base,
    input  logic [addr_width-1:0] Len,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    input  logic [n-1:0]          InData,
    input  logic                  InValid,
    output logic                  InReady,
    output logic [n-1:0]          OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  RfWE,
    output logic [addr_width-1:0] RfAddr,
    output logic [n-1:0]          RfWData,
    input  logic [n-1:0]          RfRData,
    output logic [n-1:0]          Checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DUMP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [addr_width:0] LP_REGCOUNT = regcount[addr_width:0];

    state_t                r_state;
    logic [addr_width-1:0] r_addr;
    logic [addr_width-1:0] r_remain;
    logic                  r_done;
    logic                  r_err;
    logic                  r_out_valid;
    logic [n-1:0]          r_out_data;

    logic [addr_width:0]   w_end;
    logic                  w_range_err;
    logic                  w_wr;
    logic                  w_last;

    // The range check runs one bit wider so Base+Len cannot wrap past regcount.
    assign w_end       = {1'b0, Base} + {1'b0, Len};
    assign w_range_err = (w_end > LP_REGCOUNT);
    assign w_wr        = (r_state == S_LOAD) && InValid;
    assign w_last      = (r_remain == {{(addr_width-1){1'b0}}, 1'b1});

    assign Busy     = (r_state == S_LOAD) || (r_state == S_DUMP);
    assign Done     = r_done;
    assign Err      = r_err;
    assign InReady  = (r_state == S_LOAD);
    assign OutData  = r_out_data;
    assign OutValid = r_out_valid;
    assign RfWE     = w_wr;
    assign RfAddr   = r_addr;
    assign RfWData  = w_wr ? InData : '0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (w_range_err) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_err <= 1'b0;
                            if (Len == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_addr   <= Base;
                                r_remain <= Len;
                                r_state  <= Mode ? S_DUMP : S_LOAD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (InValid) begin
                        r_addr   <= r_addr + 1'b1;
                        r_remain <= r_remain - 1'b1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DUMP: begin
                    // The output register refills whenever it is empty or being drained this cycle.
                    if (!r_out_valid || OutReady) begin
                        r_out_data  <= RfRData;
                        r_out_valid <= 1'b1;
                        r_addr      <= r_addr + 1'b1;
                        r_remain    <= r_remain - 1'b1;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (OutReady) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_done      <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef REGFILE_LOADER_CHECKSUM_EN
    logic         w_accept;
    logic         w_hs;
    logic [n-1:0] r_checksum;

    assign w_accept = (r_state == S_IDLE) && Start && !w_range_err;
    assign w_hs     = r_out_valid && OutReady;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_wr) begin
            r_checksum <= r_checksum ^ InData;
        end else if (w_hs) begin
            r_checksum <= r_checksum ^ r_out_data;
        end
    end

    assign Checksum = r_checksum;
`else
    assign Checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader: scoreboard of expected writes/reads plus literal checks.
module tb_regfile_loader;

    localparam int N  = 8;
    localparam int AW = 5;
    localparam int RC = 10;
`ifdef REGFILE_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          Clock, Reset, Start, Mode;
    logic [AW-1:0] Base, Len;
    logic          Busy, Done, Err;
    logic [N-1:0]  InData;
    logic          InValid, InReady;
    logic [N-1:0]  OutData;
    logic          OutValid, OutReady;
    logic          RfWE;
    logic [AW-1:0] RfAddr;
    logic [N-1:0]  RfWData, RfRData, Checksum;

    regfile_loader #(.n(N), .addr_width(AW), .regcount(RC)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode),
        .Base(Base), .Len(Len), .Busy(Busy), .Done(Done), .Err(Err),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .RfWE(RfWE), .RfAddr(RfAddr), .RfWData(RfWData), .RfRData(RfRData),
        .Checksum(Checksum)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Attached register file
    logic [N-1:0] tb_rf [RC];
    logic         rf_ready;
    assign RfRData = (RfAddr < AW'(RC)) ? tb_rf[RfAddr[3:0]] : '0;
    always @(posedge Clock) begin
        if (!rf_ready) begin
            for (int i = 0; i < RC; i++) tb_rf[i] <= 8'(32'hA0 + i);
        end else if (RfWE && (RfAddr < AW'(RC))) begin
            tb_rf[RfAddr[3:0]] <= RfWData;
        end
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [N-1:0]  d;
    } wr_t;

    wr_t          exp_wr[$];
    logic [N-1:0] exp_rd[$];
    logic [N-1:0] exp_rf [RC];
    logic [N-1:0] exp_ck;
    int           n_vec, n_err;
    int           cyc, hs_count, last_hs_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_wr(input int a, input logic [N-1:0] d);
        exp_wr.push_back(wr_t'{a: AW'(a), d: d});
        exp_rf[a] = d;
        exp_ck    = exp_ck ^ d;
    endtask

    task automatic push_rd(input int a);
        exp_rd.push_back(exp_rf[a]);
        exp_ck = exp_ck ^ exp_rf[a];
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_cmd(input logic m, input logic [AW-1:0] b, input logic [AW-1:0] l);
        Start = 1'b1; Mode = m; Base = b; Len = l;
        step();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (Done) begin
                got = 1;
                break;
            end
        end
        chk(name, 32'(got), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     32'(Busy), 0);
        chk({tag, "_done"},     32'(Done), 0);
        chk({tag, "_err"},      32'(Err), 0);
        chk({tag, "_inready"},  32'(InReady), 0);
        chk({tag, "_outvalid"}, 32'(OutValid), 0);
        chk({tag, "_outdata"},  32'(OutData), 0);
        chk({tag, "_rfwe"},     32'(RfWE), 0);
        chk({tag, "_rfaddr"},   32'(RfAddr), 0);
        chk({tag, "_rfwdata"},  32'(RfWData), 0);
        chk({tag, "_checksum"}, 32'(Checksum), 0);
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge Clock);
            cyc++;
        end
    end

    // Per-cycle compare against the scoreboard
    initial begin
        logic         prev_stall;
        logic [N-1:0] prev_data;
        wr_t          w;
        prev_stall = 1'b0;
        prev_data  = '0;
        hs_count   = 0;
        last_hs_cyc = 0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                prev_stall = 1'b0;
            end else begin
                if (RfWE) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_rfwe", 32'(RfAddr), 32'hFFFF);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", 32'(RfAddr), 32'(w.a));
                        chk("wr_data", 32'(RfWData), 32'(w.d));
                        chk("wr_inready", 32'(InReady), 1);
                    end
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(OutValid), 1);
                    chk("stall_data", 32'(OutData), 32'(prev_data));
                end
                if (OutValid && OutReady) begin
                    hs_count++;
                    last_hs_cyc = cyc;
                    if (exp_rd.size() == 0) chk("unexpected_out", 32'(OutData), 32'hFFFF);
                    else chk("out_data", 32'(OutData), 32'(exp_rd.pop_front()));
                end
                if (InReady && OutValid) chk("inready_with_outvalid", 1, 0);
                prev_stall = OutValid && !OutReady;
                prev_data  = OutData;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int           hs0;
        logic [7:0]   pat;
        n_vec = 0; n_err = 0;
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Base = '0; Len = '0;
        InData = '0; InValid = 1'b0; OutReady = 1'b0; rf_ready = 1'b0;
        exp_ck = '0;
        for (int i = 0; i < RC; i++) exp_rf[i] = 8'(32'hA0 + i);

        step();
        chk_all_zero("reset");
        step();
        rf_ready = 1'b1;
        Reset    = 1'b0;
        step();

        // LOAD Base=2 Len=3 with one InValid gap
        exp_ck = '0;
        push_wr(2, 8'h11); push_wr(3, 8'h22); push_wr(4, 8'h44);
        start_cmd(1'b0, 5'd2, 5'd3);
        chk("load_busy", 32'(Busy), 1);
        chk("load_inready", 32'(InReady), 1);
        chk("load_done_early", 32'(Done), 0);
        InValid = 1'b1; InData = 8'h11; step();
        InValid = 1'b0; step();
        InValid = 1'b1; InData = 8'h22; step();
        InData = 8'h44; step();
        InValid = 1'b0;
        chk("load_done", 32'(Done), 1);
        chk("load_err", 32'(Err), 0);
        chk("load_busy_end", 32'(Busy), 0);
        chk("load_ck_lit", 32'(Checksum), CK_EN ? 32'h77 : 32'h0);
        chk("load_ck_model", 32'(Checksum), CK_EN ? 32'(exp_ck) : 32'h0);
        step();
        chk("load_done_pulse", 32'(Done), 0);
        chk("load_rf3_lit", 32'(tb_rf[3]), 32'h22);
        chk("load_wr_drained", 32'(exp_wr.size()), 0);

        // DUMP Base=2 Len=3, OutReady low for two cycles
        exp_ck = '0;
        push_rd(2); push_rd(3); push_rd(4);
        hs0 = hs_count;
        OutReady = 1'b0;
        start_cmd(1'b1, 5'd2, 5'd3);
        chk("dump_busy", 32'(Busy), 1);
        chk("dump_valid_entry", 32'(OutValid), 0);
        step();
        chk("dump_valid1", 32'(OutValid), 1);
        chk("dump_data1_lit", 32'(OutData), 32'h11);
        step();
        chk("dump_hold_valid", 32'(OutValid), 1);
        chk("dump_hold_data_lit", 32'(OutData), 32'h11);
        OutReady = 1'b1;
        wait_done("dump_done", 12);
        chk("dump_hs_count", 32'(hs_count - hs0), 3);
        chk("dump_done_latency", 32'(cyc - last_hs_cyc), 1);
        chk("dump_valid_end", 32'(OutValid), 0);
        chk("dump_ck_lit", 32'(Checksum), CK_EN ? 32'h77 : 32'h0);
        chk("dump_rd_drained", 32'(exp_rd.size()), 0);
        step();
        chk("dump_done_pulse", 32'(Done), 0);

        // Range error: Base=8 Len=3 exceeds 10 registers; InValid held high as bait
        OutReady = 1'b0;
        InValid = 1'b1; InData = 8'hFF;
        start_cmd(1'b0, 5'd8, 5'd3);
        chk("rerr_err", 32'(Err), 1);
        chk("rerr_done", 32'(Done), 1);
        chk("rerr_busy", 32'(Busy), 0);
        chk("rerr_inready", 32'(InReady), 0);
        step();
        chk("rerr_done_pulse", 32'(Done), 0);
        chk("rerr_err_held", 32'(Err), 1);
        chk("rerr_busy2", 32'(Busy), 0);
        InValid = 1'b0;
        step();

        // Len=0, Base=0 in DUMP mode
        OutReady = 1'b1;
        start_cmd(1'b1, 5'd0, 5'd0);
        chk("len0_done", 32'(Done), 1);
        chk("len0_err", 32'(Err), 0);
        chk("len0_busy", 32'(Busy), 0);
        chk("len0_outvalid", 32'(OutValid), 0);
        chk("len0_ck", 32'(Checksum), 0);
        step();
        chk("len0_done_pulse", 32'(Done), 0);
        chk("len0_outvalid2", 32'(OutValid), 0);
        OutReady = 1'b0;

        // Reset after one of three LOAD words
        exp_ck = '0;
        push_wr(5, 8'hA5);
        start_cmd(1'b0, 5'd5, 5'd3);
        InValid = 1'b1; InData = 8'hA5; step();
        InData = 8'h5A;
        #2 Reset = 1'b1;
        #1 chk_all_zero("midreset");
        InValid = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b0;
        step();
        chk("midreset_no_done", 32'(Done), 0);
        step();
        chk("midreset_no_done2", 32'(Done), 0);
        chk("midreset_wr_drained", 32'(exp_wr.size()), 0);

        // Normal LOAD after reset
        exp_ck = '0;
        push_wr(5, 8'h0F); push_wr(6, 8'hF0);
        start_cmd(1'b0, 5'd5, 5'd2);
        InValid = 1'b1; InData = 8'h0F; step();
        InData = 8'hF0; step();
        InValid = 1'b0;
        chk("reload_done", 32'(Done), 1);
        chk("reload_ck", 32'(Checksum), CK_EN ? 32'hFF : 32'h0);
        chk("reload_rf6_lit", 32'(tb_rf[6]), 32'hF0);
        step();

        // DUMP Base=0 Len=7 with backpressure and a Start pulse while busy
        exp_ck = '0;
        for (int a = 0; a < 7; a++) push_rd(a);
        hs0 = hs_count;
        pat = 8'b1011_0010;
        start_cmd(1'b1, 5'd0, 5'd7);
        begin
            int got;
            got = 0;
            for (int i = 0; i < 60 && got == 0; i++) begin
                OutReady = pat[i % 8];
                if (i == 3) begin
                    Start = 1'b1; Mode = 1'b0; Base = 5'd5; Len = 5'd1;
                end else begin
                    Start = 1'b0;
                end
                step();
                if (Done) got = 1;
            end
            Start = 1'b0;
            chk("dump7_done", 32'(got), 1);
        end
        chk("dump7_hs_count", 32'(hs_count - hs0), 7);
        chk("dump7_rd_drained", 32'(exp_rd.size()), 0);
        chk("dump7_err", 32'(Err), 0);
        chk("dump7_ck_lit", 32'(Checksum), CK_EN ? 32'h89 : 32'h0);
        chk("dump7_ck_model", 32'(Checksum), CK_EN ? 32'(exp_ck) : 32'h0);
        OutReady = 1'b0;
        step();
        chk("dump7_idle_busy", 32'(Busy), 0);
        chk("dump7_no_stray_wr", 32'(exp_wr.size()), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_loader.md
REGFILE_LOADER -- requirements
Module: regfile_loader

Interface
REQ-001 SHALL have parameter n, default 8, data word width.
REQ-002 SHALL have parameter addr_width, default 5, register address width.
REQ-003 SHALL have parameter regcount, default 10, number of registers in the attached register file.
REQ-004 SHALL have port Clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port Start  in  1  command strobe, sampled only in IDLE.
REQ-007 SHALL have port Mode  in  1  0 = LOAD (stream into register file), 1 = DUMP (register file to stream).
REQ-008 SHALL have port Base  in  addr_width  first register address.
REQ-009 SHALL have port Len  in  addr_width  word count.
REQ-010 SHALL have port Busy  out  1  high in LOAD and DUMP states.
REQ-011 SHALL have port Done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port Err  out  1  range error flag for the last command.
REQ-013 SHALL have port InData  in  n, InValid  in  1, InReady  out  1  LOAD input stream.
REQ-014 SHALL have port OutData  out  n, OutValid  out  1, OutReady  in  1  DUMP output stream.
REQ-015 SHALL have port RfWE  out  1, RfAddr  out  addr_width, RfWData  out  n  register-file write and address side.
REQ-016 SHALL have port RfRData  in  n  combinational read data from the register file at RfAddr.
REQ-017 SHALL have port Checksum  out  n  running XOR of transferred words.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DUMP, DRAIN; Start in IDLE latches Base, Len, Mode; Start outside IDLE is ignored.
REQ-019 SHALL, on Start with Base+Len > regcount (computed at addr_width+1 bits), stay IDLE, set Err=1, pulse Done next cycle, and issue no RfWE.
REQ-020 SHALL, on Start with Len=0 and no range error, pulse Done next cycle with Err=0 and no register access.
REQ-021 SHALL clear Err on every accepted Start that does not have a range error.
REQ-022 SHALL, in LOAD, drive InReady=1; on InValid&&InReady the same cycle SHALL drive RfWE=1, RfAddr=current address, RfWData=InData, then increment the address.
REQ-023 SHALL drive RfWE=0 at all times outside a LOAD transfer cycle.
REQ-024 SHALL, after the Len-th LOAD write, return to IDLE and pulse Done in the following cycle.
REQ-025 SHALL, in DUMP, load the registered OutData from RfRData and advance the address whenever !OutValid||OutReady; first OutValid appears one cycle after entering DUMP.
REQ-026 SHALL hold OutData and OutValid stable while OutValid&&!OutReady.
REQ-027 SHALL enter DRAIN after the Len-th read, leave on the final OutValid&&OutReady handshake, and pulse Done on return to IDLE.
REQ-028 SHALL hold InReady=0 outside LOAD and OutValid=0 outside DUMP/DRAIN.

Reset
REQ-029 SHALL, while Reset=1, force state IDLE and set Busy, Done, Err, InReady, OutValid, OutData, RfWE, RfAddr, RfWData, and Checksum to 0, regardless of Clock.
REQ-030 SHALL abandon any in-progress transfer on Reset without a Done pulse.

Configuration
REQ-031 SHALL, with macro REGFILE_LOADER_CHECKSUM_EN defined, clear Checksum on accepted Start and XOR in every word written (LOAD) or handshaken out (DUMP).
REQ-032 SHALL, without REGFILE_LOADER_CHECKSUM_EN, tie Checksum to 0 and contain no checksum register.

Verification
REQ-033 SHALL cover: LOAD Base=2 Len=3, data 0x11,0x22,0x44 with one InValid gap -> RfWE at addr 2,3,4 with those data; Done 1 cycle after last write; Checksum=0x77 (macro on).
REQ-034 SHALL cover: DUMP Base=2 Len=3 after the previous scenario, OutReady low 2 cycles at start -> OutData 0x11 held, then 0x22, 0x44; Done after third handshake.
REQ-035 SHALL cover: Start Base=8 Len=3 -> Err=1, Done pulse, RfWE never asserted, Busy stays 0.
REQ-036 SHALL cover: Start Len=0 Base=0 -> Done next cycle, Err=0, no RfWE, no OutValid.
REQ-037 SHALL cover: Reset asserted mid-LOAD after 1 of 3 words -> all outputs 0 immediately; subsequent Start operates normally.
REQ-038 SHALL cover: Start pulsed while Busy in DUMP -> ignored; the transfer completes with the original Base/Len.
